stopwatch_counter: RTL and testbench

- Time-accumulation stage of the stopwatch. Consumes a 1 Hz tick from the upstream prescaler and start/stop/clear pulses from the button debouncer.
- Holds a 4-digit BCD MM:SS count and passes it to the seven-segment display driver.
- Every digit increment goes through the team's CSA adder, one instance per digit, with b=0 and the digit's carry-in driving ci.
- Adds the run/pause/idle control FSM and the digit-to-digit carry chain.

---
 rtl/stopwatch_counter_pkg.sv | 18 +
 rtl/stopwatch_counter_if.sv | 23 ++
 rtl/bcd_digit.sv | 41 ++++
 rtl/csa.sv | 13 +
 rtl/stopwatch_counter.sv | 111 +++++++++++
 tb/tb_stopwatch_counter.sv | 157 +++++++++++++++
 6 files changed

// File: rtl/stopwatch_counter_pkg.sv
// rtl/stopwatch_counter_pkg.sv - shared constants and FSM encoding for the stopwatch counter
// Contents: DIGIT_W (BCD digit width), state_t (ST_IDLE/ST_RUN/ST_PAUSE),
//           default digit limits used by the top-level parameters.
package stopwatch_counter_pkg;

    localparam int DIGIT_W = 4;

    localparam int DEF_SEC_TENS_MAX = 5;
    localparam int DEF_MIN_TENS_MAX = 5;
    localparam logic [DIGIT_W-1:0] UNITS_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - control/display bundle between stopwatch counter and its neighbours
// Signals: tick, start_stop, clear (and lap when STOPWATCH_LAP_EN) into the counter;
//          digits[15:0], running, wrap out of the counter.
// Modports: master = upstream driver / display side, slave = stopwatch_counter.
interface stopwatch_counter_if;
    logic        tick;
    logic        start_stop;
    logic        clear;
`ifdef STOPWATCH_LAP_EN
    logic        lap;
`endif
    logic [15:0] digits;
    logic        running;
    logic        wrap;

`ifdef STOPWATCH_LAP_EN
    modport master (output tick, start_stop, clear, lap, input digits, running, wrap);
    modport slave  (input tick, start_stop, clear, lap, output digits, running, wrap);
`else
    modport master (output tick, start_stop, clear, input digits, running, wrap);
    modport slave  (input tick, start_stop, clear, output digits, running, wrap);
`endif
endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit register with increment, limit rollover and carry-out
// Ports: clk, reset (async, active-high), clr (sync zero), inc (carry-in),
//        limit[3:0] (last value before rollover); q[3:0] digit, carry (rollover this cycle).
module bcd_digit
    import stopwatch_counter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    input  logic [DIGIT_W-1:0] limit,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);
    logic [DIGIT_W-1:0] r_q;
    logic [DIGIT_W-1:0] w_sum;
    logic               w_co_unused;
    logic               w_at_limit;

    // Adder carry-out is not needed: the limit compare decides rollover.
    csa #(.W(DIGIT_W)) u_csa (
        .a   (r_q),
        .b   ({DIGIT_W{1'b0}}),
        .ci  (inc),
        .sum (w_sum),
        .co  (w_co_unused)
    );

    assign w_at_limit = (r_q == limit);
    assign carry      = inc & w_at_limit;
    assign q          = r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_q <= '0;
        else if (clr)
            r_q <= '0;
        else if (inc)
            r_q <= w_at_limit ? '0 : w_sum;
    end
endmodule

// File: rtl/csa.sv
// rtl/csa.sv - W-bit adder of two vectors plus a carry-in
// Ports: a[W-1:0], b[W-1:0], ci in; sum[W-1:0], co out.
module csa #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS BCD stopwatch with run/pause/idle FSM and digit carry chain
// Ports: clk, reset (async, active-high); bus (stopwatch_counter_if.slave):
//        tick, start_stop, clear, [lap] in; digits[15:0] {mt,mu,st,su}, running, wrap out.
// Parameters: SEC_TENS_MAX, MIN_TENS_MAX, SAT_AT_MAX (0 wrap, 1 hold maximum and pause).
// Optional: STOPWATCH_LAP_EN adds the lap freeze of the displayed digits.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int SEC_TENS_MAX = DEF_SEC_TENS_MAX,
    parameter int MIN_TENS_MAX = DEF_MIN_TENS_MAX,
    parameter int SAT_AT_MAX   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    stopwatch_counter_if.slave    bus
);
    localparam logic [DIGIT_W-1:0] L_ST = DIGIT_W'(SEC_TENS_MAX);
    localparam logic [DIGIT_W-1:0] L_MT = DIGIT_W'(MIN_TENS_MAX);
    localparam bit                 SAT  = (SAT_AT_MAX != 0);

    state_t               r_state;
    state_t               w_next;
    logic                 w_running;
    logic                 r_wrap;
    logic                 w_count_en;
    logic                 w_at_max;
    logic                 w_inc_su;
    logic                 w_c_su, w_c_st, w_c_mu, w_c_mt_unused;
    logic [DIGIT_W-1:0]   w_su, w_st, w_mu, w_mt;
    logic [15:0]          w_live;

    // clear outranks the tick; start_stop does not block a tick while running.
    assign w_count_en = (r_state == ST_RUN) && bus.tick && !bus.clear;
    assign w_at_max   = (w_su == UNITS_MAX) && (w_st == L_ST) &&
                        (w_mu == UNITS_MAX) && (w_mt == L_MT);
    // In saturating mode the maximum is held, so the chain is never started.
    assign w_inc_su   = w_count_en && !(SAT && w_at_max);

    bcd_digit u_su (.clk(clk), .reset(reset), .clr(bus.clear), .inc(w_inc_su),
                    .limit(UNITS_MAX), .q(w_su), .carry(w_c_su));
    bcd_digit u_st (.clk(clk), .reset(reset), .clr(bus.clear), .inc(w_c_su),
                    .limit(L_ST), .q(w_st), .carry(w_c_st));
    bcd_digit u_mu (.clk(clk), .reset(reset), .clr(bus.clear), .inc(w_c_st),
                    .limit(UNITS_MAX), .q(w_mu), .carry(w_c_mu));
    bcd_digit u_mt (.clk(clk), .reset(reset), .clr(bus.clear), .inc(w_c_mu),
                    .limit(L_MT), .q(w_mt), .carry(w_c_mt_unused));

    assign w_live = {w_mt, w_mu, w_st, w_su};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (bus.start_stop) w_next = ST_RUN;
                ST_RUN:   if (bus.start_stop || (SAT && w_count_en && w_at_max))
                              w_next = ST_PAUSE;
                ST_PAUSE: if (bus.start_stop) w_next = ST_RUN;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_running = (r_state == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_count_en && w_at_max;
    end

    assign bus.running = w_running;
    assign bus.wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
    logic        r_lap_active;
    logic [15:0] r_lap;

    // Freeze captures the count as it stands before this edge's tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap_active <= 1'b0;
            r_lap        <= '0;
        end else if (bus.clear) begin
            r_lap_active <= 1'b0;
        end else if (bus.lap) begin
            if (r_lap_active) begin
                r_lap_active <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_lap_active <= 1'b1;
                r_lap        <= w_live;
            end
        end
    end

    assign bus.digits = r_lap_active ? r_lap : w_live;
`else
    assign bus.digits = w_live;
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed self-checking bench for stopwatch_counter (wrap and saturate builds)
module tb_stopwatch_counter;
    logic clk = 1'b0;
    logic reset;
    logic tick, start_stop, clear;
`ifdef STOPWATCH_LAP_EN
    logic lap;
`endif
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stopwatch_counter_if u_if0 ();
    stopwatch_counter_if u_if1 ();

    assign u_if0.tick = tick;  assign u_if0.start_stop = start_stop;  assign u_if0.clear = clear;
    assign u_if1.tick = tick;  assign u_if1.start_stop = start_stop;  assign u_if1.clear = clear;
`ifdef STOPWATCH_LAP_EN
    assign u_if0.lap = lap;
    assign u_if1.lap = lap;
`endif

    stopwatch_counter #(.SAT_AT_MAX(0)) u_dut0 (.clk(clk), .reset(reset), .bus(u_if0.slave));
    stopwatch_counter #(.SAT_AT_MAX(1)) u_dut1 (.clk(clk), .reset(reset), .bus(u_if1.slave));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied after the falling edge, outputs read 1 ns after the rising edge.
    task automatic cyc(input logic t, input logic ss, input logic cl, input logic lp);
        @(negedge clk);
        tick = t; start_stop = ss; clear = cl;
`ifdef STOPWATCH_LAP_EN
        lap = lp;
`endif
        @(posedge clk);
        #1;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b1; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", u_if0.digits, 16'h0000);
        chk("rst_running", {15'd0, u_if0.running}, 16'd0);
        chk("rst_wrap", {15'd0, u_if0.wrap}, 16'd0);
        chk("rst_digits_sat", u_if1.digits, 16'h0000);
        @(negedge clk);
        reset = 1'b0; tick = 1'b0;

        ticks(5);
        chk("idle_ticks", u_if0.digits, 16'h0000);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        chk("run_10", u_if0.digits, 16'h0010);
        chk("run_running", {15'd0, u_if0.running}, 16'd1);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        chk("pause_hold", u_if0.digits, 16'h0010);
        chk("pause_running", {15'd0, u_if0.running}, 16'd0);

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear", u_if0.digits, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(59);
        chk("at_0059", u_if0.digits, 16'h0059);
        ticks(1);
        chk("sec_roll", u_if0.digits, 16'h0100);
        ticks(539);
        chk("at_0959", u_if0.digits, 16'h0959);
        ticks(1);
        chk("min_roll", u_if0.digits, 16'h1000);
        ticks(2999);
        chk("at_max_wrap", u_if0.digits, 16'h5959);
        chk("at_max_sat", u_if1.digits, 16'h5959);

        ticks(1);
        chk("wrap_digits", u_if0.digits, 16'h0000);
        chk("wrap_pulse", {15'd0, u_if0.wrap}, 16'd1);
        chk("wrap_running", {15'd0, u_if0.running}, 16'd1);
        chk("sat_digits", u_if1.digits, 16'h5959);
        chk("sat_pulse", {15'd0, u_if1.wrap}, 16'd1);
        chk("sat_running", {15'd0, u_if1.running}, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_one_cycle", {15'd0, u_if0.wrap}, 16'd0);
        chk("sat_one_cycle", {15'd0, u_if1.wrap}, 16'd0);

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        chk("at_0004", u_if0.digits, 16'h0004);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("tick_ss_digits", u_if0.digits, 16'h0005);
        chk("tick_ss_running", {15'd0, u_if0.running}, 16'd0);
        ticks(1);
        chk("paused_after", u_if0.digits, 16'h0005);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_to_run", {15'd0, u_if0.running}, 16'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(83);
        chk("at_0123", u_if0.digits, 16'h0123);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("tick_clear_digits", u_if0.digits, 16'h0000);
        chk("tick_clear_running", {15'd0, u_if0.running}, 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("idle_ss_tick_dropped", u_if0.digits, 16'h0000);
        chk("idle_ss_running", {15'd0, u_if0.running}, 16'd1);

        ticks(7);
        chk("at_0007", u_if0.digits, 16'h0007);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_digits", u_if0.digits, 16'h0000);
        chk("async_rst_running", {15'd0, u_if0.running}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef STOPWATCH_LAP_EN
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(12);
        chk("lap_at_0012", u_if0.digits, 16'h0012);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(5);
        chk("lap_frozen", u_if0.digits, 16'h0012);
        chk("lap_running", {15'd0, u_if0.running}, 16'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_release", u_if0.digits, 16'h0017);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
